// File: rtl/branch_recovery_ctrl_pkg.sv
// Shared types and helpers for the branch misprediction recovery controller.
// The ROB index width lives here so the entry type and the age helper follow it.
package branch_recovery_pkg;

    localparam int BRC_NUM_BRANCH  = 2;
    localparam int BRC_ROB_IDX_W   = 7;
    localparam int BRC_RESTORE_MIN = 2;

    typedef enum logic [1:0] {
        BRC_IDLE,
        BRC_FLUSH,
        BRC_RESTORE
    } brc_state_t;

    typedef struct packed {
        logic [BRC_ROB_IDX_W-1:0] idx;
        logic [31:0]              pc;
    } brc_entry_t;

    // Distance from the ROB head; wraps naturally at the index width, smaller is older.
    function automatic logic [BRC_ROB_IDX_W-1:0] rob_age(
        input logic [BRC_ROB_IDX_W-1:0] idx,
        input logic [BRC_ROB_IDX_W-1:0] head
    );
        return idx - head;
    endfunction

endpackage

// File: rtl/branch_recovery_ctrl_if.sv
// Bundle between branch execute / ROB / rename and the recovery controller.
// Optional statistics outputs appear when BRANCH_RECOVERY_STATS_EN is defined.
interface branch_recovery_ctrl_if
    import branch_recovery_pkg::*;
#(
    parameter int NUM_BRANCH = BRC_NUM_BRANCH
`ifdef BRANCH_RECOVERY_STATS_EN
  , parameter int STAT_W     = 32
`endif
);

    logic [NUM_BRANCH-1:0]                    res_valid;
    logic [NUM_BRANCH-1:0]                    res_mispredicted;
    logic [NUM_BRANCH-1:0][31:0]              res_correct_pc;
    logic [NUM_BRANCH-1:0][BRC_ROB_IDX_W-1:0] res_rob_idx;
    logic [BRC_ROB_IDX_W-1:0]                 rob_head_idx;
    logic                                     exc_flush;
    logic                                     ckpt_restore_done;

    logic                                     flush;
    logic [BRC_ROB_IDX_W-1:0]                 flush_rob_idx;
    logic                                     redirect_valid;
    logic [31:0]                              redirect_pc;
    logic                                     ckpt_restore_req;
    logic [BRC_ROB_IDX_W-1:0]                 ckpt_restore_idx;
    logic                                     recover_busy;

`ifdef BRANCH_RECOVERY_STATS_EN
    logic [STAT_W-1:0]                        stat_resolved;
    logic [STAT_W-1:0]                        stat_mispred;
`endif

    // Controller side.
    modport slave (
`ifdef BRANCH_RECOVERY_STATS_EN
        output stat_resolved,
        output stat_mispred,
`endif
        input  res_valid,
        input  res_mispredicted,
        input  res_correct_pc,
        input  res_rob_idx,
        input  rob_head_idx,
        input  exc_flush,
        input  ckpt_restore_done,
        output flush,
        output flush_rob_idx,
        output redirect_valid,
        output redirect_pc,
        output ckpt_restore_req,
        output ckpt_restore_idx,
        output recover_busy
    );

    // Pipeline side that produces resolutions and consumes recovery controls.
    modport master (
`ifdef BRANCH_RECOVERY_STATS_EN
        input  stat_resolved,
        input  stat_mispred,
`endif
        output res_valid,
        output res_mispredicted,
        output res_correct_pc,
        output res_rob_idx,
        output rob_head_idx,
        output exc_flush,
        output ckpt_restore_done,
        input  flush,
        input  flush_rob_idx,
        input  redirect_valid,
        input  redirect_pc,
        input  ckpt_restore_req,
        input  ckpt_restore_idx,
        input  recover_busy
    );

endinterface

// File: rtl/branch_recovery_ctrl_age_select.sv
// Combinational oldest-candidate selector across the resolution lanes.
// Ties on age go to the lowest lane.
module branch_age_select
    import branch_recovery_pkg::*;
#(
    parameter  int NUM_BRANCH = BRC_NUM_BRANCH,
    localparam int LANE_W     = (NUM_BRANCH > 1) ? $clog2(NUM_BRANCH) : 1
) (
    input  logic [NUM_BRANCH-1:0]                    cand_i,
    input  logic [NUM_BRANCH-1:0][BRC_ROB_IDX_W-1:0] idx_i,
    input  logic [NUM_BRANCH-1:0][31:0]              pc_i,
    input  logic [BRC_ROB_IDX_W-1:0]                 head_i,
    output logic                                     found_o,
    output logic [LANE_W-1:0]                        lane_o,
    output logic [BRC_ROB_IDX_W-1:0]                 idx_o,
    output logic [31:0]                              pc_o
);

    logic [BRC_ROB_IDX_W-1:0] bestAge;

    // Linear scan; strict less-than keeps the earlier lane on equal age.
    always_comb begin
        found_o = 1'b0;
        lane_o  = '0;
        idx_o   = '0;
        pc_o    = '0;
        bestAge = '0;
        for (int i = 0; i < NUM_BRANCH; i++) begin
            if (cand_i[i] && (!found_o || rob_age(idx_i[i], head_i) < bestAge)) begin
                found_o = 1'b1;
                lane_o  = LANE_W'(i);
                idx_o   = idx_i[i];
                pc_o    = pc_i[i];
                bestAge = rob_age(idx_i[i], head_i);
            end
        end
    end

endmodule

// File: rtl/branch_recovery_ctrl.sv
// Misprediction recovery scheduler: picks the oldest mispredicting lane, issues a
// one-cycle flush/redirect/checkpoint-restore pulse, waits for the restore, and
// keeps one older pending mispredict seen during recovery.
// Optional feature macro: BRANCH_RECOVERY_STATS_EN (resolution/mispredict counters).
module branch_recovery_ctrl
    import branch_recovery_pkg::*;
#(
    parameter int NUM_BRANCH  = BRC_NUM_BRANCH,
    parameter int RESTORE_MIN = BRC_RESTORE_MIN
`ifdef BRANCH_RECOVERY_STATS_EN
  , parameter int STAT_W      = 32
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    branch_recovery_ctrl_if.slave bus
);

    localparam int LANE_W = (NUM_BRANCH > 1) ? $clog2(NUM_BRANCH) : 1;
    localparam int CNT_W  = 4;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RESTORE_MIN - 1);

    brc_state_t               state_q;
    logic [CNT_W-1:0]         cnt_q;
    brc_entry_t               cur_q;
    logic                     pend_valid_q;
    brc_entry_t               pend_q;
    logic                     flush_q;
    logic                     busy_q;

    logic                     sel_found;
    logic [LANE_W-1:0]        sel_lane;
    logic [BRC_ROB_IDX_W-1:0] sel_idx;
    logic [31:0]              sel_pc;

    brc_entry_t               cand_entry;
    brc_entry_t               idle_winner;
    logic [BRC_ROB_IDX_W-1:0] cand_age;
    logic [BRC_ROB_IDX_W-1:0] cur_age;
    logic [BRC_ROB_IDX_W-1:0] pend_age;
    logic                     pend_capture;

    branch_age_select #(.NUM_BRANCH(NUM_BRANCH)) u_select (
        .cand_i  (bus.res_valid & bus.res_mispredicted),
        .idx_i   (bus.res_rob_idx),
        .pc_i    (bus.res_correct_pc),
        .head_i  (bus.rob_head_idx),
        .found_o (sel_found),
        .lane_o  (sel_lane),
        .idx_o   (sel_idx),
        .pc_o    (sel_pc)
    );

    // The selected target must be the one reported on the winning lane.
    always_comb begin
        assert (!sel_found || sel_pc == bus.res_correct_pc[sel_lane]);
    end

    // Age comparisons against the current head decide winner and pending replacement.
    always_comb begin
        cand_entry   = '{idx: sel_idx, pc: sel_pc};
        cand_age     = rob_age(sel_idx, bus.rob_head_idx);
        cur_age      = rob_age(cur_q.idx, bus.rob_head_idx);
        pend_age     = rob_age(pend_q.idx, bus.rob_head_idx);
        idle_winner  = (pend_valid_q && (!sel_found || pend_age < cand_age)) ? pend_q : cand_entry;
        pend_capture = sel_found && (cand_age < cur_age) && (!pend_valid_q || cand_age < pend_age);
    end

    // Recovery FSM with pending slot; exception flush overrides everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= BRC_IDLE;
            cnt_q        <= '0;
            cur_q        <= '0;
            pend_valid_q <= 1'b0;
            pend_q       <= '0;
            flush_q      <= 1'b0;
            busy_q       <= 1'b0;
        end else if (bus.exc_flush) begin
            state_q      <= BRC_IDLE;
            cnt_q        <= '0;
            pend_valid_q <= 1'b0;
            flush_q      <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            case (state_q)
                BRC_IDLE: begin
                    if (sel_found || pend_valid_q) begin
                        state_q      <= BRC_FLUSH;
                        cur_q        <= idle_winner;
                        pend_valid_q <= 1'b0;
                        flush_q      <= 1'b1;
                        busy_q       <= 1'b1;
                    end
                end
                BRC_FLUSH: begin
                    state_q <= BRC_RESTORE;
                    cnt_q   <= CNT_LOAD;
                    flush_q <= 1'b0;
                    if (pend_capture) begin
                        pend_valid_q <= 1'b1;
                        pend_q       <= cand_entry;
                    end
                end
                BRC_RESTORE: begin
                    if (cnt_q == '0 && bus.ckpt_restore_done) begin
                        state_q <= BRC_IDLE;
                        busy_q  <= 1'b0;
                    end else if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                    if (pend_capture) begin
                        pend_valid_q <= 1'b1;
                        pend_q       <= cand_entry;
                    end
                end
                default: begin
                    state_q <= BRC_IDLE;
                    flush_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.flush            = flush_q;
    assign bus.redirect_valid   = flush_q;
    assign bus.ckpt_restore_req = flush_q;
    assign bus.flush_rob_idx    = cur_q.idx;
    assign bus.ckpt_restore_idx = cur_q.idx;
    assign bus.redirect_pc      = cur_q.pc;
    assign bus.recover_busy     = busy_q;

`ifdef BRANCH_RECOVERY_STATS_EN
    logic [STAT_W-1:0] stat_res_q;
    logic [STAT_W-1:0] stat_mis_q;

    // Free-running wrap-around counters; only reset clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_res_q <= '0;
            stat_mis_q <= '0;
        end else begin
            stat_res_q <= stat_res_q + STAT_W'($countones(bus.res_valid));
            if (state_q == BRC_FLUSH) begin
                stat_mis_q <= stat_mis_q + 1'b1;
            end
        end
    end

    assign bus.stat_resolved = stat_res_q;
    assign bus.stat_mispred  = stat_mis_q;
`endif

endmodule

// File: tb/tb_branch_recovery_ctrl.sv
// Self-checking bench for branch_recovery_ctrl: directed vector table, hand-written
// multi-cycle sequences and a randomized run against a behavioural reference model.
// Build with BRANCH_RECOVERY_STATS_EN defined to also check the statistics counters.
module tb_branch_recovery_ctrl;
    import branch_recovery_pkg::*;

    localparam int NB   = 2;
    localparam int RMIN = 2;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    branch_recovery_ctrl_if #(.NUM_BRANCH(NB)) bus();

    branch_recovery_ctrl #(.NUM_BRANCH(NB), .RESTORE_MIN(RMIN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int passes = 0;

    // Reference model: a recovery is either "flushing now" or "waiting for restore";
    // the pending mispredict is a queue of at most one entry.
    bit          mBusy;
    bit          mInFlush;
    int          mElapsed;
    int          mCurIdx;
    logic [31:0] mCurPc;
    int          mPendIdx[$];
    logic [31:0] mPendPc[$];
    logic [31:0] mStatRes;
    logic [31:0] mStatMis;
    int          flushLog[$];

    typedef struct {
        logic [1:0]  v;
        logic [1:0]  m;
        int          i0;
        int          i1;
        logic [31:0] p0;
        logic [31:0] p1;
        int          head;
        logic        eFlush;
        logic        eBusy;
        int          eIdx;
        logic [31:0] ePc;
    } vec_t;

    vec_t vecs[$];

    function automatic int ageOf(input int idx, input int head);
        return (idx - head + 128) % 128;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic applyStimulus(input logic [1:0] v, input logic [1:0] m,
                                 input int i0, input int i1,
                                 input logic [31:0] p0, input logic [31:0] p1,
                                 input int head, input logic exc, input logic done);
        bus.res_valid         = v;
        bus.res_mispredicted  = m;
        bus.res_rob_idx[0]    = 7'(i0);
        bus.res_rob_idx[1]    = 7'(i1);
        bus.res_correct_pc[0] = p0;
        bus.res_correct_pc[1] = p1;
        bus.rob_head_idx      = 7'(head);
        bus.exc_flush         = exc;
        bus.ckpt_restore_done = done;
    endtask

    task automatic modelStep();
        int          head;
        bit          cFound;
        int          cIdx;
        int          cAge;
        logic [31:0] cPc;
        if (rst) begin
            mBusy = 0; mInFlush = 0; mElapsed = 0; mCurIdx = 0; mCurPc = '0;
            mPendIdx.delete(); mPendPc.delete();
            mStatRes = '0; mStatMis = '0;
        end else begin
            head = int'(bus.rob_head_idx);
            mStatRes += 32'($countones(bus.res_valid));
            if (mInFlush) mStatMis += 1;
            cFound = 0; cIdx = 0; cAge = 0; cPc = '0;
            for (int l = 0; l < NB; l++) begin
                if (bus.res_valid[l] && bus.res_mispredicted[l]) begin
                    if (!cFound || ageOf(int'(bus.res_rob_idx[l]), head) < cAge) begin
                        cFound = 1;
                        cIdx   = int'(bus.res_rob_idx[l]);
                        cAge   = ageOf(cIdx, head);
                        cPc    = bus.res_correct_pc[l];
                    end
                end
            end
            if (bus.exc_flush) begin
                mBusy = 0; mInFlush = 0;
                mPendIdx.delete(); mPendPc.delete();
            end else if (!mBusy) begin
                if (mPendIdx.size() > 0 && (!cFound || ageOf(mPendIdx[0], head) < cAge)) begin
                    mCurIdx = mPendIdx[0]; mCurPc = mPendPc[0];
                    mBusy = 1; mInFlush = 1;
                end else if (cFound) begin
                    mCurIdx = cIdx; mCurPc = cPc;
                    mBusy = 1; mInFlush = 1;
                end
                if (mBusy) begin
                    mPendIdx.delete(); mPendPc.delete();
                end
            end else begin
                if (mInFlush) begin
                    mInFlush = 0;
                    mElapsed = 0;
                end else begin
                    mElapsed++;
                    if (mElapsed >= RMIN && bus.ckpt_restore_done) mBusy = 0;
                end
                if (cFound && cAge < ageOf(mCurIdx, head) &&
                    (mPendIdx.size() == 0 || cAge < ageOf(mPendIdx[0], head))) begin
                    mPendIdx.delete(); mPendPc.delete();
                    mPendIdx.push_back(cIdx); mPendPc.push_back(cPc);
                end
            end
        end
    endtask

    // One clock: advance the model with the inputs seen at the edge, then compare.
    task automatic stepCycle();
        @(posedge clk);
        modelStep();
        #1;
        checkOutput("model_pulses", {28'd0, bus.flush, bus.redirect_valid, bus.ckpt_restore_req, bus.recover_busy},
                    {28'd0, mInFlush, mInFlush, mInFlush, mBusy});
        if (mInFlush) begin
            checkOutput("model_flush_idx", 32'(bus.flush_rob_idx), 32'(mCurIdx));
            checkOutput("model_ckpt_idx", 32'(bus.ckpt_restore_idx), 32'(mCurIdx));
            checkOutput("model_redirect_pc", bus.redirect_pc, mCurPc);
        end
`ifdef BRANCH_RECOVERY_STATS_EN
        checkOutput("model_stat_resolved", bus.stat_resolved, mStatRes);
        checkOutput("model_stat_mispred", bus.stat_mispred, mStatMis);
`endif
        if (bus.flush === 1'b1) flushLog.push_back(int'(bus.flush_rob_idx));
    endtask

    task automatic idleCycles(input int n, input logic done);
        for (int k = 0; k < n; k++) begin
            applyStimulus(2'b00, 2'b00, 0, 0, 32'h0, 32'h0, 0, 1'b0, done);
            stepCycle();
        end
    endtask

    task automatic doReset();
        rst = 1'b1;
        applyStimulus(2'b00, 2'b00, 0, 0, 32'h0, 32'h0, 0, 1'b0, 1'b0);
        stepCycle();
        stepCycle();
        rst = 1'b0;
        flushLog.delete();
    endtask

    task automatic addRow(input logic [1:0] v, input logic [1:0] m, input int i0, input int i1,
                          input logic [31:0] p0, input logic [31:0] p1, input int head,
                          input logic eFlush, input logic eBusy, input int eIdx, input logic [31:0] ePc);
        vec_t r;
        r.v = v; r.m = m; r.i0 = i0; r.i1 = i1; r.p0 = p0; r.p1 = p1; r.head = head;
        r.eFlush = eFlush; r.eBusy = eBusy; r.eIdx = eIdx; r.ePc = ePc;
        vecs.push_back(r);
    endtask

    task automatic addIdleTail(input int head);
        addRow(2'b00, 2'b00, 0, 0, 32'h0, 32'h0, head, 1'b0, 1'b1, 0, 32'h0);
        addRow(2'b00, 2'b00, 0, 0, 32'h0, 32'h0, head, 1'b0, 1'b1, 0, 32'h0);
        addRow(2'b00, 2'b00, 0, 0, 32'h0, 32'h0, head, 1'b0, 1'b0, 0, 32'h0);
    endtask

    initial begin
        logic [31:0] statRes0;
        logic [31:0] statMis0;
        statRes0 = '0;
        statMis0 = '0;

        doReset();
        checkOutput("reset_flush", 32'(bus.flush), 32'd0);
        checkOutput("reset_redirect_valid", 32'(bus.redirect_valid), 32'd0);
        checkOutput("reset_ckpt_req", 32'(bus.ckpt_restore_req), 32'd0);
        checkOutput("reset_busy", 32'(bus.recover_busy), 32'd0);
        checkOutput("reset_flush_idx", 32'(bus.flush_rob_idx), 32'd0);
        checkOutput("reset_redirect_pc", bus.redirect_pc, 32'd0);
`ifdef BRANCH_RECOVERY_STATS_EN
        checkOutput("reset_stat_resolved", bus.stat_resolved, 32'd0);
        checkOutput("reset_stat_mispred", bus.stat_mispred, 32'd0);
`endif

        // Directed table: single lane, oldest-of-two at two heads, non-mispredict lanes,
        // equal-age tie and head wrap-around. Done is held high throughout.
        addRow(2'b01, 2'b01, 5, 0, 32'h0040_0100, 32'h0, 0, 1'b1, 1'b1, 5, 32'h0040_0100);
        addIdleTail(0);
        addRow(2'b11, 2'b11, 10, 3, 32'h0000_A000, 32'h0000_B000, 0, 1'b1, 1'b1, 3, 32'h0000_B000);
        addIdleTail(0);
        addRow(2'b11, 2'b11, 10, 3, 32'h0000_A000, 32'h0000_B000, 8, 1'b1, 1'b1, 10, 32'h0000_A000);
        addIdleTail(8);
        addRow(2'b11, 2'b00, 4, 9, 32'h0000_4000, 32'h0000_9000, 0, 1'b0, 1'b0, 0, 32'h0);
        addRow(2'b11, 2'b11, 7, 7, 32'h0000_7000, 32'h0000_7001, 0, 1'b1, 1'b1, 7, 32'h0000_7000);
        addIdleTail(0);
        addRow(2'b11, 2'b11, 2, 125, 32'h0000_0200, 32'h0000_7D00, 120, 1'b1, 1'b1, 125, 32'h0000_7D00);
        addIdleTail(120);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].v, vecs[i].m, vecs[i].i0, vecs[i].i1,
                          vecs[i].p0, vecs[i].p1, vecs[i].head, 1'b0, 1'b1);
            stepCycle();
            checkOutput($sformatf("vec%0d_flush", i), 32'(bus.flush), 32'(vecs[i].eFlush));
            checkOutput($sformatf("vec%0d_busy", i), 32'(bus.recover_busy), 32'(vecs[i].eBusy));
            if (vecs[i].eFlush) begin
                checkOutput($sformatf("vec%0d_idx", i), 32'(bus.flush_rob_idx), 32'(vecs[i].eIdx));
                checkOutput($sformatf("vec%0d_pc", i), bus.redirect_pc, vecs[i].ePc);
            end
        end

        // Older mispredict during RESTORE is held and flushed after return to IDLE.
        doReset();
        applyStimulus(2'b01, 2'b01, 20, 0, 32'h0000_2000, 32'h0, 0, 1'b0, 1'b0);
        stepCycle();
        idleCycles(1, 1'b0);
        applyStimulus(2'b01, 2'b01, 12, 0, 32'h0000_1200, 32'h0, 0, 1'b0, 1'b0);
        stepCycle();
        idleCycles(8, 1'b1);
        checkOutput("pending_flush_count", 32'(flushLog.size()), 32'd2);
        if (flushLog.size() >= 2) checkOutput("pending_flush_idx", 32'(flushLog[1]), 32'd12);

        // Younger mispredict during RESTORE is dropped.
        doReset();
        applyStimulus(2'b01, 2'b01, 20, 0, 32'h0000_2000, 32'h0, 0, 1'b0, 1'b0);
        stepCycle();
        idleCycles(1, 1'b0);
        applyStimulus(2'b10, 2'b10, 0, 30, 32'h0, 32'h0000_3000, 0, 1'b0, 1'b0);
        stepCycle();
        idleCycles(8, 1'b1);
        checkOutput("younger_flush_count", 32'(flushLog.size()), 32'd1);

        // Restore done held low keeps busy; then an exception flush mid-RESTORE.
        doReset();
        applyStimulus(2'b01, 2'b01, 20, 0, 32'h0000_2000, 32'h0, 0, 1'b0, 1'b0);
        stepCycle();
        for (int k = 0; k < 6; k++) begin
            idleCycles(1, 1'b0);
            checkOutput($sformatf("done_low_busy%0d", k), 32'(bus.recover_busy), 32'd1);
        end
        idleCycles(1, 1'b1);
        checkOutput("done_rise_busy", 32'(bus.recover_busy), 32'd0);

        flushLog.delete();
        applyStimulus(2'b01, 2'b01, 20, 0, 32'h0000_2000, 32'h0, 0, 1'b0, 1'b0);
        stepCycle();
        idleCycles(1, 1'b0);
        applyStimulus(2'b01, 2'b01, 12, 0, 32'h0000_1200, 32'h0, 0, 1'b0, 1'b0);
        stepCycle();
        applyStimulus(2'b00, 2'b00, 0, 0, 32'h0, 32'h0, 0, 1'b1, 1'b0);
        stepCycle();
        checkOutput("exc_busy", 32'(bus.recover_busy), 32'd0);
        checkOutput("exc_flush_pulse", 32'(bus.flush), 32'd0);
        idleCycles(6, 1'b1);
        checkOutput("exc_no_more_flush", 32'(flushLog.size()), 32'd1);

        // Exception and mispredict in the same IDLE cycle: nothing is taken.
        doReset();
`ifdef BRANCH_RECOVERY_STATS_EN
        statRes0 = bus.stat_resolved;
        statMis0 = bus.stat_mispred;
`endif
        applyStimulus(2'b11, 2'b11, 5, 6, 32'h0000_0500, 32'h0000_0600, 0, 1'b1, 1'b0);
        stepCycle();
        checkOutput("exc_idle_flush", 32'(bus.flush), 32'd0);
        checkOutput("exc_idle_redirect", 32'(bus.redirect_valid), 32'd0);
`ifdef BRANCH_RECOVERY_STATS_EN
        checkOutput("exc_idle_stat_resolved", bus.stat_resolved - statRes0, 32'd2);
        checkOutput("exc_idle_stat_mispred", bus.stat_mispred - statMis0, 32'd0);
`endif
        idleCycles(1, 1'b1);
        checkOutput("exc_idle_flush_after", 32'(bus.flush), 32'd0);

        // Randomized run against the reference model.
        doReset();
        for (int c = 0; c < 2000; c++) begin
            applyStimulus(2'($urandom_range(0, 3)),
                          2'($urandom_range(0, 3)) & 2'($urandom_range(0, 3)),
                          int'($urandom_range(0, 127)), int'($urandom_range(0, 127)),
                          $urandom, $urandom,
                          int'($urandom_range(0, 127)),
                          ($urandom_range(0, 39) == 0),
                          ($urandom_range(0, 3) != 0));
            stepCycle();
        end

        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
